dsp_ctx_sequencer: RTL and testbench

- Per-tile context sequencer for the tile's DSP48E-style ALU/multiplier slice.
- Holds a small context memory of control words: ALUMODE, OPMODE, INMODE, CARRYIN.
- On start, replays the contexts in order for a programmed number of loop iterations, driving the slice's control strings and alu_en each cycle.
- Tracks the slice's registered-P latency to flag valid results; ends with a done pulse.

---
 rtl/dsp_ctrl_pkg.sv | 36 +++
 rtl/dsp_ctx_mem.sv | 27 ++
 rtl/dsp_ctx_sequencer.sv | 161 ++++++++++++++++
 tb/tb_dsp_ctx_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_ctrl_pkg.sv
// Shared definitions for the DSP slice context sequencer: context word layout,
// named slice control codes and sequencer state encoding.
package dsp_ctrl_pkg;

    localparam int CTX_W = 17;

    localparam int CARRYIN_LSB = 0;
    localparam int INMODE_LSB  = 1;
    localparam int INMODE_W    = 5;
    localparam int OPMODE_LSB  = 6;
    localparam int OPMODE_W    = 7;
    localparam int ALUMODE_LSB = 13;
    localparam int ALUMODE_W   = 4;

    typedef struct packed {
        logic [ALUMODE_W-1:0] alumode;
        logic [OPMODE_W-1:0]  opmode;
        logic [INMODE_W-1:0]  inmode;
        logic                 carryin;
    } ctx_word_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [6:0] OPM_ZERO = 7'b0000000;
    localparam logic [6:0] OPM_MUL  = 7'b0000101;
    localparam logic [4:0] INM_A_B  = 5'b00000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic ctx_word_t unpack_ctx(input logic [CTX_W-1:0] w);
        return ctx_word_t'(w);
    endfunction

endpackage

// File: rtl/dsp_ctx_mem.sv
// Context register file: synchronous write, asynchronous read, no reset
// (contents are always programmed before use).
module dsp_ctx_mem
    import dsp_ctrl_pkg::*;
#(
    parameter int NUM_CTX = 8,
    parameter int CTX_AW  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [CTX_AW-1:0] waddr,
    input  logic [CTX_W-1:0]  wdata,
    input  logic [CTX_AW-1:0] raddr,
    output logic [CTX_W-1:0]  rdata
);

    logic [CTX_W-1:0] mem [NUM_CTX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dsp_ctx_sequencer.sv
// Replays programmed DSP slice control contexts for a number of passes and
// tracks the slice's P latency to flag valid results.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; config writes accepted; controls hold
//   ST_RUN   | issuing ctx[pc] each non-stalled cycle
//   ST_DRAIN | all issues done; waiting for last result to leave latency pipe
module dsp_ctx_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int NUM_CTX = 8,
    parameter int CTX_AW  = 3,
    parameter int P_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CTX_AW-1:0] cfg_addr,
    input  logic [CTX_W-1:0]  cfg_data,
    input  logic [CTX_AW-1:0] cfg_last,
    input  logic [7:0]        loop_cnt,
    input  logic              start,
    input  logic              stall,
    input  logic              abort,
    output logic [3:0]        alumode,
    output logic [6:0]        opmode,
    output logic [4:0]        inmode,
    output logic              carryin,
    output logic              alu_en,
    output logic [CTX_AW-1:0] ctx_idx,
    output logic              p_valid,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [CTX_AW-1:0] LAST_MAX = CTX_AW'(NUM_CTX - 1);

    logic [1:0]        state;
    logic [CTX_AW-1:0] pc;
    logic [CTX_AW-1:0] last;
    logic [7:0]        iter;
    logic [7:0]        loops;
    logic [P_LAT-1:0]  lat_pipe;
    logic [CTX_W-1:0]  rd_data;
    ctx_word_t         rd_word;
    logic              drain_ok;

    dsp_ctx_mem #(
        .NUM_CTX (NUM_CTX),
        .CTX_AW  (CTX_AW)
    ) u_mem (
        .clk   (clk),
        .we    (cfg_we && (state == ST_IDLE)),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (pc),
        .rdata (rd_data)
    );

    assign rd_word = unpack_ctx(rd_data);
    assign p_valid = lat_pipe[P_LAT-1];

    // Leaving DRAIN is safe once only the oldest stage can still be set:
    // that result shows on p_valid this cycle and done follows it.
    always_comb begin
        drain_ok = !alu_en;
        for (int i = 0; i < P_LAT - 1; i++) begin
            if (lat_pipe[i]) begin
                drain_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            last     <= '0;
            iter     <= '0;
            loops    <= '0;
            lat_pipe <= '0;
            alumode  <= '0;
            opmode   <= '0;
            inmode   <= '0;
            carryin  <= 1'b0;
            alu_en   <= 1'b0;
            ctx_idx  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            done        <= 1'b0;
            cfg_err     <= cfg_we && (state != ST_IDLE);
            lat_pipe[0] <= alu_en;
            for (int i = 1; i < P_LAT; i++) begin
                lat_pipe[i] <= lat_pipe[i-1];
            end

            case (state)
                ST_IDLE: begin
                    alu_en <= 1'b0;
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        last  <= (int'(cfg_last) > NUM_CTX - 1) ? LAST_MAX : cfg_last;
                        loops <= loop_cnt;
                        pc    <= '0;
                        iter  <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        alu_en   <= 1'b0;
                        lat_pipe <= '0;
                    end else if (stall) begin
                        alu_en <= 1'b0;
                    end else begin
                        alumode <= rd_word.alumode;
                        opmode  <= rd_word.opmode;
                        inmode  <= rd_word.inmode;
                        carryin <= rd_word.carryin;
                        alu_en  <= 1'b1;
                        ctx_idx <= pc;
                        if (pc == last) begin
                            pc <= '0;
                            if (iter == loops) begin
                                state <= ST_DRAIN;
                            end else begin
                                iter <= iter + 8'd1;
                            end
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    alu_en <= 1'b0;
                    if (abort) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        lat_pipe <= '0;
                    end else if (drain_ok) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    alu_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_ctx_sequencer.sv
// Directed bench for dsp_ctx_sequencer: vector table for the main runs plus
// hand sequences for P_LAT=3 draining and asynchronous reset mid-run.
module tb_dsp_ctx_sequencer;

    localparam logic [16:0] C0 = 17'b0000_0000101_00001_0;
    localparam logic [16:0] C1 = 17'b0011_0110011_00101_1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [16:0] cfg_data = '0;
    logic [2:0]  cfg_last = '0;
    logic [7:0]  loop_cnt = '0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        abort = 1'b0;

    logic [3:0] alumode, alumode_3;
    logic [6:0] opmode, opmode_3;
    logic [4:0] inmode, inmode_3;
    logic       carryin, carryin_3;
    logic       alu_en, alu_en_3;
    logic [2:0] ctx_idx, ctx_idx_3;
    logic       p_valid, p_valid_3;
    logic       busy, busy_3;
    logic       done, done_3;
    logic       cfg_err, cfg_err_3;

    int n_chk = 0;
    int n_fail = 0;
    logic [16:0] model_ctx [2];

    always #5 clk = ~clk;

    dsp_ctx_sequencer #(.NUM_CTX(8), .CTX_AW(3), .P_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .loop_cnt(loop_cnt),
        .start(start), .stall(stall), .abort(abort),
        .alumode(alumode), .opmode(opmode), .inmode(inmode), .carryin(carryin),
        .alu_en(alu_en), .ctx_idx(ctx_idx), .p_valid(p_valid), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    dsp_ctx_sequencer #(.NUM_CTX(8), .CTX_AW(3), .P_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .loop_cnt(loop_cnt),
        .start(start), .stall(stall), .abort(abort),
        .alumode(alumode_3), .opmode(opmode_3), .inmode(inmode_3), .carryin(carryin_3),
        .alu_en(alu_en_3), .ctx_idx(ctx_idx_3), .p_valid(p_valid_3), .busy(busy_3),
        .done(done_3), .cfg_err(cfg_err_3)
    );

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [16:0] data;
        logic        start;
        logic [2:0]  last;
        logic [7:0]  loops;
        logic        stall;
        logic        abort;
        logic        e_alu;
        logic [2:0]  e_idx;
        logic        e_pv;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic we, input logic [2:0] addr, input logic [16:0] data,
                                input logic st, input logic [2:0] last, input logic [7:0] loops,
                                input logic stl, input logic ab, input logic e_alu,
                                input logic [2:0] e_idx, input logic e_pv, input logic e_busy,
                                input logic e_done, input logic e_err);
        vec_t v;
        v.we = we; v.addr = addr; v.data = data; v.start = st; v.last = last;
        v.loops = loops; v.stall = stl; v.abort = ab; v.e_alu = e_alu; v.e_idx = e_idx;
        v.e_pv = e_pv; v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
        vecs.push_back(v);
    endfunction

    // Cycle with no write/start: stall, abort, then expected alu_en, idx, p_valid, busy, done.
    function automatic void cyc(input logic stl, input logic ab, input logic e_alu,
                                input logic [2:0] e_idx, input logic e_pv, input logic e_busy,
                                input logic e_done);
        add(1'b0, 3'd0, 17'd0, 1'b0, 3'd0, 8'd0, stl, ab, e_alu, e_idx, e_pv, e_busy, e_done, 1'b0);
    endfunction

    function automatic void go(input logic [2:0] last, input logic [7:0] loops);
        add(1'b0, 3'd0, 17'd0, 1'b1, last, loops, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input logic [3:0] am, input logic [6:0] om,
                            input logic [4:0] im, input logic ci, input logic [16:0] exp);
        chk({tag, " ctrl word"}, {am, om, im, ci}, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " dut outs"}, {alumode, opmode, inmode, carryin, alu_en, ctx_idx, p_valid, busy, done, cfg_err}, 32'd0);
        chk({tag, " dut3 outs"}, {alumode_3, opmode_3, inmode_3, carryin_3, alu_en_3, ctx_idx_3, p_valid_3, busy_3, done_3, cfg_err_3}, 32'd0);
    endtask

    initial begin
        model_ctx[0] = C0;
        model_ctx[1] = C1;

        step();
        step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Basic run: 2 contexts x 3 passes; start mid-run must be ignored.
        add(1'b1, 3'd0, C0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 3'd1, C1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        go(3'd1, 8'd2);
        cyc(0, 0, 1, 3'd0, 0, 1, 0);
        cyc(0, 0, 1, 3'd1, 1, 1, 0);
        add(1'b0, 3'd0, 17'd0, 1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(0, 0, 1, 3'd1, 1, 1, 0);
        cyc(0, 0, 1, 3'd0, 1, 1, 0);
        cyc(0, 0, 1, 3'd1, 1, 1, 0);
        cyc(0, 0, 0, 3'd0, 1, 1, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 1);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);

        // Stall on RUN cycles 3-4, plus a dropped write to ctx1 while busy.
        go(3'd1, 8'd2);
        cyc(0, 0, 1, 3'd0, 0, 1, 0);
        add(1'b1, 3'd1, 17'h1FFFF, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1, 0, 0, 3'd0, 1, 1, 0);
        cyc(1, 0, 0, 3'd0, 0, 1, 0);
        cyc(0, 0, 1, 3'd0, 0, 1, 0);
        cyc(0, 0, 1, 3'd1, 1, 1, 0);
        cyc(0, 0, 1, 3'd0, 1, 1, 0);
        cyc(0, 0, 1, 3'd1, 1, 1, 0);
        cyc(1, 0, 0, 3'd0, 1, 1, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 1);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);

        // Abort on the 4th issue cycle (with stall/start also high), then restart.
        go(3'd1, 8'd2);
        cyc(0, 0, 1, 3'd0, 0, 1, 0);
        cyc(0, 0, 1, 3'd1, 1, 1, 0);
        cyc(0, 0, 1, 3'd0, 1, 1, 0);
        cyc(0, 0, 1, 3'd1, 1, 1, 0);
        add(1'b0, 3'd0, 17'd0, 1'b1, 3'd1, 8'd2, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 1, 0, 3'd0, 0, 0, 0);
        go(3'd1, 8'd0);
        cyc(0, 0, 1, 3'd0, 0, 1, 0);
        cyc(0, 0, 1, 3'd1, 1, 1, 0);
        cyc(0, 0, 0, 3'd0, 1, 1, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 1);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);
        cyc(0, 0, 0, 3'd0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [16:0] m;
            cfg_we   = vecs[i].we;
            cfg_addr = vecs[i].addr;
            cfg_data = vecs[i].data;
            start    = vecs[i].start;
            cfg_last = vecs[i].last;
            loop_cnt = vecs[i].loops;
            stall    = vecs[i].stall;
            abort    = vecs[i].abort;
            step();
            chk($sformatf("v%0d alu_en", i), alu_en, vecs[i].e_alu);
            chk($sformatf("v%0d p_valid", i), p_valid, vecs[i].e_pv);
            chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d done", i), done, vecs[i].e_done);
            chk($sformatf("v%0d cfg_err", i), cfg_err, vecs[i].e_err);
            if (vecs[i].e_alu) begin
                m = model_ctx[vecs[i].e_idx];
                chk($sformatf("v%0d ctx_idx", i), ctx_idx, vecs[i].e_idx);
                chk_ctrl($sformatf("v%0d", i), alumode, opmode, inmode, carryin, m);
            end
        end
        cfg_we = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;

        // Single-context program: P_LAT=3 drain timing (and P_LAT=1 alongside).
        cfg_last = 3'd0; loop_cnt = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("s0 busy3", busy_3, 1'b1);
        chk("s0 alu3", alu_en_3, 1'b0);
        step();
        chk("s1 alu3", alu_en_3, 1'b1);
        chk("s1 idx3", ctx_idx_3, 3'd0);
        chk_ctrl("s1 dut3", alumode_3, opmode_3, inmode_3, carryin_3, C0);
        chk("s1 alu", alu_en, 1'b1);
        step();
        chk("s2 alu3", alu_en_3, 1'b0);
        chk("s2 pv3", p_valid_3, 1'b0);
        chk("s2 pv", p_valid, 1'b1);
        step();
        chk("s3 pv3", p_valid_3, 1'b0);
        chk("s3 done", done, 1'b1);
        chk("s3 busy3", busy_3, 1'b1);
        step();
        chk("s4 pv3", p_valid_3, 1'b1);
        chk("s4 done3", done_3, 1'b0);
        chk("s4 done", done, 1'b0);
        step();
        chk("s5 pv3", p_valid_3, 1'b0);
        chk("s5 done3", done_3, 1'b1);
        chk("s5 busy3", busy_3, 1'b0);
        step();
        chk("s6 done3", done_3, 1'b0);

        // Asynchronous reset in the middle of a run; contexts must survive it.
        cfg_last = 3'd1; loop_cnt = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("r pre alu", alu_en, 1'b1);
        chk("r pre idx", ctx_idx, 3'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async rst");
        step();
        chk_all_zero("held rst");
        #3;
        rst_n = 1'b1;
        step();
        chk("r idle busy", busy, 1'b0);
        cfg_last = 3'd1; loop_cnt = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("r busy", busy, 1'b1);
        step();
        chk("r i0 alu", alu_en, 1'b1);
        chk("r i0 idx", ctx_idx, 3'd0);
        chk_ctrl("r i0", alumode, opmode, inmode, carryin, C0);
        step();
        chk("r i1 idx", ctx_idx, 3'd1);
        chk("r i1 pv", p_valid, 1'b1);
        chk_ctrl("r i1", alumode, opmode, inmode, carryin, C1);
        step();
        chk("r drain alu", alu_en, 1'b0);
        step();
        chk("r done", done, 1'b1);
        step();
        chk("r done clr", done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
